// File: rtl/tcam_lpm_search_if.sv
// Search-side bundle of the TCAM LPM block: handshake, key, the eight entry/length
// read lines, the occupancy vector and the registered result.
interface tcam_lpm_search_if #(
  parameter int WIDTH      = 32,
  parameter int LEN_WIDTH  = 6,
  parameter int INDEX_SIZE = 3
);
  logic                  go;
  logic [WIDTH-1:0]      key;
  logic [WIDTH-1:0]      entry0, entry1, entry2, entry3, entry4, entry5, entry6, entry7;
  logic [LEN_WIDTH-1:0]  len0, len1, len2, len3, len4, len5, len6, len7;
  logic [7:0]            occupied;
  logic [INDEX_SIZE-1:0] index;
  logic                  found;
  logic                  done;

  modport master (
    output go, key,
    output entry0, entry1, entry2, entry3, entry4, entry5, entry6, entry7,
    output len0, len1, len2, len3, len4, len5, len6, len7,
    output occupied,
    input  index, found, done
  );

  modport slave (
    input  go, key,
    input  entry0, entry1, entry2, entry3, entry4, entry5, entry6, entry7,
    input  len0, len1, len2, len3, len4, len5, len6, len7,
    input  occupied,
    output index, found, done
  );
endinterface

// File: rtl/tcam_lpm_search.sv
// Longest-prefix-match search over eight TCAM entries, one entry per cycle,
// under a go/done handshake. Results are registered and held until the next search.
module tcam_lpm_search #(
  parameter int WIDTH      = 32,
  parameter int LEN_WIDTH  = 6,
  parameter int INDEX_SIZE = 3
) (
  input  logic clk,
  input  logic reset,
  tcam_lpm_search_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r, state_next_s;
  logic [WIDTH-1:0]      key_r;
  logic [INDEX_SIZE-1:0] ptr_r;
  logic [INDEX_SIZE-1:0] best_idx_r;
  logic [LEN_WIDTH-1:0]  best_len_r;
  logic                  hit_r;
  logic [INDEX_SIZE-1:0] index_r;
  logic                  found_r;
  logic                  done_r;

  logic [WIDTH-1:0]      cur_entry_s;
  logic [LEN_WIDTH-1:0]  cur_len_s;
  logic [LEN_WIDTH-1:0]  eff_len_s;
  logic [WIDTH-1:0]      mask_s;
  logic                  match_s;
  logic                  take_s;

  // Top-l-bits mask; the extra bit keeps l=0 (shift by WIDTH) in range.
  function automatic logic [WIDTH-1:0] prefix_mask(input logic [LEN_WIDTH-1:0] l);
    logic [WIDTH:0] low_ones;
    low_ones = ((WIDTH+1)'(1) << (WIDTH - int'(l))) - (WIDTH+1)'(1);
    return ~low_ones[WIDTH-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; go is only honoured while idle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.go) begin
          state_next_s = SCAN;
        end else begin
          state_next_s = IDLE;
        end
      end
      SCAN: begin
        if (ptr_r == {INDEX_SIZE{1'b1}}) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SCAN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Select the entry and length under the scan pointer.
  always_comb begin
    cur_entry_s = bus.entry0;
    cur_len_s   = bus.len0;
    case (ptr_r)
      3'd0: begin cur_entry_s = bus.entry0; cur_len_s = bus.len0; end
      3'd1: begin cur_entry_s = bus.entry1; cur_len_s = bus.len1; end
      3'd2: begin cur_entry_s = bus.entry2; cur_len_s = bus.len2; end
      3'd3: begin cur_entry_s = bus.entry3; cur_len_s = bus.len3; end
      3'd4: begin cur_entry_s = bus.entry4; cur_len_s = bus.len4; end
      3'd5: begin cur_entry_s = bus.entry5; cur_len_s = bus.len5; end
      3'd6: begin cur_entry_s = bus.entry6; cur_len_s = bus.len6; end
      3'd7: begin cur_entry_s = bus.entry7; cur_len_s = bus.len7; end
      default: begin cur_entry_s = bus.entry0; cur_len_s = bus.len0; end
    endcase
  end

  // Match and priority for the current entry; over-long prefixes clamp to WIDTH.
  always_comb begin
    eff_len_s = cur_len_s;
    if (cur_len_s > LEN_WIDTH'(WIDTH)) begin
      eff_len_s = LEN_WIDTH'(WIDTH);
    end else begin
      eff_len_s = cur_len_s;
    end
    mask_s  = prefix_mask(eff_len_s);
    match_s = bus.occupied[ptr_r] && (((key_r ^ cur_entry_s) & mask_s) == {WIDTH{1'b0}});
    take_s  = match_s && (!hit_r || (eff_len_s > best_len_r));
  end

  // Search datapath and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_r      <= {WIDTH{1'b0}};
      ptr_r      <= {INDEX_SIZE{1'b0}};
      best_idx_r <= {INDEX_SIZE{1'b0}};
      best_len_r <= {LEN_WIDTH{1'b0}};
      hit_r      <= 1'b0;
      index_r    <= {INDEX_SIZE{1'b0}};
      found_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.go) begin
            key_r      <= bus.key;
            ptr_r      <= {INDEX_SIZE{1'b0}};
            best_idx_r <= {INDEX_SIZE{1'b0}};
            best_len_r <= {LEN_WIDTH{1'b0}};
            hit_r      <= 1'b0;
          end
        end
        SCAN: begin
          ptr_r <= ptr_r + INDEX_SIZE'(1);
          if (take_s) begin
            hit_r      <= 1'b1;
            best_len_r <= eff_len_s;
            best_idx_r <= ptr_r;
          end
        end
        DONE: begin
          done_r  <= 1'b1;
          found_r <= hit_r;
          index_r <= hit_r ? best_idx_r : {INDEX_SIZE{1'b0}};
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.index = index_r;
  assign bus.found = found_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_tcam_lpm_search.sv
// Randomized bench for tcam_lpm_search: a per-cycle compare against an LPM model
// computed from snapshots of what each entry held when it was scanned.
module tb_tcam_lpm_search;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  logic chk_en;
  logic exp_done;
  logic exp_found;
  logic [2:0] exp_index;

  logic [31:0] ent [8];
  logic [5:0]  ln  [8];
  logic [7:0]  occ;

  tcam_lpm_search_if #(.WIDTH(32), .LEN_WIDTH(6), .INDEX_SIZE(3)) bus ();

  tcam_lpm_search #(.WIDTH(32), .LEN_WIDTH(6), .INDEX_SIZE(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are compared on every falling edge once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      n_total++;
      if (bus.done !== exp_done || bus.found !== exp_found || bus.index !== exp_index)
        $display("FAIL outputs t=%0t got done=%b found=%b index=%0d want done=%b found=%b index=%0d",
                 $time, bus.done, bus.found, bus.index, exp_done, exp_found, exp_index);
      else
        n_pass++;
    end
  end

  task automatic drive();
    bus.entry0 = ent[0]; bus.entry1 = ent[1]; bus.entry2 = ent[2]; bus.entry3 = ent[3];
    bus.entry4 = ent[4]; bus.entry5 = ent[5]; bus.entry6 = ent[6]; bus.entry7 = ent[7];
    bus.len0 = ln[0]; bus.len1 = ln[1]; bus.len2 = ln[2]; bus.len3 = ln[3];
    bus.len4 = ln[4]; bus.len5 = ln[5]; bus.len6 = ln[6]; bus.len7 = ln[7];
    bus.occupied = occ;
  endtask

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want)
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    else
      n_pass++;
  endtask

  // Reference LPM: compare key and entry by their top L bits with plain shifts.
  function automatic void lpm(input logic [31:0] k, input logic [31:0] e [8],
                              input logic [5:0] l [8], input logic [7:0] o,
                              output logic f, output logic [2:0] idx);
    int best;
    f = 1'b0; idx = 3'd0; best = 0;
    for (int i = 0; i < 8; i++) begin
      int  len;
      bit  m;
      len = (int'(l[i]) > 32) ? 32 : int'(l[i]);
      m = o[i] && (len == 0 || ((k >> (32 - len)) == (e[i] >> (32 - len))));
      if (m && (!f || len > best)) begin
        f = 1'b1; idx = 3'(i); best = len;
      end
    end
  endfunction

  // One search; starts and ends just after a rising edge with the DUT idle.
  task automatic run_search(input logic [31:0] k, input int go_again, input int rst_at,
                            input bit wr);
    logic [31:0] se [8];
    logic [5:0]  sl [8];
    logic [7:0]  so;
    logic        ef;
    logic [2:0]  ei;
    so = 8'd0;
    bus.key = k;
    bus.go  = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (wr) begin
        bus.key = $urandom;
        if ($urandom_range(0, 2) == 0) begin
          int j;
          j = $urandom_range(0, 7);
          ent[j] = $urandom_range(0, 1) ? k : $urandom;
          ln[j]  = 6'($urandom_range(0, 40));
          occ[j] = 1'($urandom_range(0, 1));
          drive();
        end
      end
      bus.go = (i == go_again) ? 1'b1 : 1'b0;
      if (i == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.go = 1'b0;
        exp_found = 1'b0;
        exp_index = 3'd0;
        return;
      end
      se[i] = ent[i]; sl[i] = ln[i]; so[i] = occ[i];
      @(posedge clk); #1;
    end
    bus.go = 1'b0;
    @(posedge clk); #1;
    lpm(k, se, sl, so, ef, ei);
    exp_done  = 1'b1;
    exp_found = ef;
    exp_index = ef ? ei : 3'd0;
    @(posedge clk); #1;
    exp_done = 1'b0;
  endtask

  task automatic fill(input logic [31:0] e, input logic [5:0] l, input logic [7:0] o);
    for (int i = 0; i < 8; i++) begin
      ent[i] = e; ln[i] = l;
    end
    occ = o;
  endtask

  initial begin
    n_pass = 0; n_total = 0; chk_en = 1'b0;
    exp_done = 1'b0; exp_found = 1'b0; exp_index = 3'd0;
    reset = 1'b1; bus.go = 1'b0; bus.key = 32'd0;
    fill(32'hFFFF_FFFF, 6'd32, 8'h00);
    drive();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Empty table.
    run_search(32'hDEAD_BEEF, -1, -1, 1'b0);
    check_lit("t1_found", 32'(bus.found), 32'd0);
    check_lit("t1_index", 32'(bus.index), 32'd0);

    // Nested prefixes.
    fill(32'hFFFF_FFFF, 6'd32, 8'hFF);
    ent[2] = 32'h0A00_0000; ln[2] = 6'd8;
    ent[5] = 32'h0A0B_0000; ln[5] = 6'd16;
    drive();
    run_search(32'h0A0B_0C0D, -1, -1, 1'b0);
    check_lit("t2_found", 32'(bus.found), 32'd1);
    check_lit("t2_index_long", 32'(bus.index), 32'd5);
    run_search(32'h0AFF_0000, -1, -1, 1'b0);
    check_lit("t2_index_short", 32'(bus.index), 32'd2);

    // Equal lengths: lower index wins.
    fill(32'hFFFF_FFFF, 6'd32, 8'hFF);
    ent[1] = 32'hC0A8_0000; ln[1] = 6'd16;
    ent[6] = 32'hC0A8_0000; ln[6] = 6'd16;
    drive();
    run_search(32'hC0A8_0001, -1, -1, 1'b0);
    check_lit("t3_tie_index", 32'(bus.index), 32'd1);

    // Default route only.
    fill(32'h0000_0000, 6'd32, 8'h80);
    ent[7] = 32'hABCD_0000; ln[7] = 6'd0;
    drive();
    run_search(32'h1234_5678, -1, -1, 1'b0);
    check_lit("t3_default_found", 32'(bus.found), 32'd1);
    check_lit("t3_default_index", 32'(bus.index), 32'd7);

    // Length beyond WIDTH clamps to an exact match.
    fill(32'h0000_0000, 6'd32, 8'h08);
    ent[3] = 32'h55AA_55AA; ln[3] = 6'd40;
    drive();
    run_search(32'h55AA_55AA, -1, -1, 1'b0);
    check_lit("t4_exact_index", 32'(bus.index), 32'd3);
    run_search(32'h55AA_55AB, -1, -1, 1'b0);
    check_lit("t4_miss_found", 32'(bus.found), 32'd0);

    // go during scan is ignored; reset mid-scan aborts without a done pulse.
    fill(32'hFFFF_FFFF, 6'd32, 8'hFF);
    ent[2] = 32'h0A00_0000; ln[2] = 6'd8;
    ent[5] = 32'h0A0B_0000; ln[5] = 6'd16;
    drive();
    run_search(32'h0A0B_0C0D, 4, -1, 1'b0);
    check_lit("t5_go_ignored_index", 32'(bus.index), 32'd5);
    run_search(32'h0A0B_0C0D, -1, 3, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check_lit("t5_reset_found", 32'(bus.found), 32'd0);
    run_search(32'h0AFF_1234, -1, -1, 1'b0);
    check_lit("t5_after_reset_index", 32'(bus.index), 32'd2);

    // Random tables, keys near entries, live writes during the scan.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] k;
      for (int i = 0; i < 8; i++) begin
        ent[i] = $urandom;
        ln[i]  = 6'($urandom_range(0, 40));
      end
      occ = 8'($urandom);
      drive();
      k = ent[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1) k = k ^ (32'd1 << $urandom_range(0, 31));
      run_search(k, -1, -1, (t % 2) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
